memory_rack: RTL and testbench



---
 rtl/memory_rack_pkg.sv | 32 +++
 rtl/memory_rack_delay_tank.sv | 32 +++
 rtl/memory_rack.sv | 171 +++++++++++++++++
 tb/tb_memory_rack.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_rack_pkg.sv
// Shared types and width helpers for the EDSAC store rack: op codes,
// sequencer states and address widths derived from the rack geometry.
package memory_rack_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_code_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_DONE
    } rack_state_e;

    // Index width for a counter or selector over n items, never narrower than 1.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NUM_TANKS  = 8;
    localparam int DEF_STORE_LEN  = 16;
    localparam int DEF_WORD_WIDTH = 36;

    localparam int TANK_AW  = addr_width(DEF_NUM_TANKS);
    localparam int WORD_AW  = addr_width(DEF_STORE_LEN);
    localparam int DIGIT_AW = addr_width(DEF_WORD_WIDTH);

endpackage

// File: rtl/memory_rack_delay_tank.sv
// One circulating delay-line tank: the bit leaving bit[0] re-enters at the top
// every cycle unless the sequencer replaces it with new data.
module delay_tank #(
    parameter int LEN = 576
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           replace,
    input  logic           repl_bit,
    output logic           out_bit,
    output logic [LEN-1:0] contents
);

    logic [LEN-1:0] bits;
    logic           in_bit;

    assign out_bit  = bits[0];
    assign contents = bits;
    assign in_bit   = replace ? repl_bit : bits[0];

    // NOTE: the store is built from flops rather than a RAM macro, so it clears
    // on reset like any other state; a real RAM could not be reset this way.
    // NOTE: sequential state always uses <= so every tank sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits <= '0;
        end else begin
            bits <= {in_bit, bits[LEN-1:1]};
        end
    end

endmodule

// File: rtl/memory_rack.sv
// EDSAC store rack: NUM_TANKS lockstep circulating tanks, a shared digit/word
// timing chain, and a req/ack/done sequencer that gates one window transfer.
module memory_rack
    import memory_rack_pkg::*;
#(
    parameter int NUM_TANKS  = DEF_NUM_TANKS,
    parameter int STORE_LEN  = DEF_STORE_LEN,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
    input  logic                                 rack_clk,
    input  logic                                 rack_rst_n,
    input  logic                                 op_req,
    input  logic [1:0]                           op_code,
    input  logic [addr_width(NUM_TANKS)-1:0]     op_tank,
    input  logic [addr_width(STORE_LEN)-1:0]     op_word,
    input  logic                                 op_whole,
    input  logic                                 mib,
    output logic                                 op_ack,
    output logic                                 op_done,
    output logic                                 busy,
    output logic                                 mob,
    output logic                                 mob_valid,
    output logic [addr_width(WORD_WIDTH)-1:0]    digit_pos,
    output logic [addr_width(STORE_LEN)-1:0]     word_pos,
    input  logic [addr_width(NUM_TANKS)-1:0]     mon_sel,
    output logic [STORE_LEN*WORD_WIDTH-1:0]      monitor
);

    localparam int T_AW     = addr_width(NUM_TANKS);
    localparam int W_AW     = addr_width(STORE_LEN);
    localparam int D_AW     = addr_width(WORD_WIDTH);
    localparam int TANK_LEN = STORE_LEN * WORD_WIDTH;

    // ------------------------------------------------------------------
    // Timing chain
    // ------------------------------------------------------------------
    logic            digit_last;
    logic            word_last;
    logic [D_AW-1:0] digit_nxt;
    logic [W_AW-1:0] word_nxt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        digit_last = (digit_pos == D_AW'(WORD_WIDTH - 1));
        word_last  = (word_pos == W_AW'(STORE_LEN - 1));
        digit_nxt  = digit_last ? '0 : digit_pos + 1'b1;
        word_nxt   = word_pos;
        if (digit_last) begin
            word_nxt = word_last ? '0 : word_pos + 1'b1;
        end
    end

    always_ff @(posedge rack_clk or negedge rack_rst_n) begin
        if (!rack_rst_n) begin
            digit_pos <= '0;
            word_pos  <= '0;
        end else begin
            digit_pos <= digit_nxt;
            word_pos  <= word_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Transfer sequencer
    // ------------------------------------------------------------------
    rack_state_e     state;
    op_code_e        cur_code;
    logic [T_AW-1:0] cur_tank;
    logic [W_AW-1:0] cur_word;
    logic            cur_whole;

    logic            req_valid;
    logic [W_AW-1:0] start_word;
    logic            at_start;
    logic            xfer_last;

    always_comb begin
        req_valid  = op_req && (op_code_e'(op_code) != OP_RSVD)
                     && (32'(op_tank) < NUM_TANKS);
        start_word = cur_whole ? '0 : cur_word;
        // The edge that moves the chain onto digit 0 of the start word opens the window.
        at_start   = digit_last && (word_nxt == start_word);
        xfer_last  = digit_last && (!cur_whole || word_last);
    end

    always_ff @(posedge rack_clk or negedge rack_rst_n) begin
        if (!rack_rst_n) begin
            state     <= ST_IDLE;
            cur_code  <= OP_READ;
            cur_tank  <= '0;
            cur_word  <= '0;
            cur_whole <= 1'b0;
            op_ack    <= 1'b0;
            op_done   <= 1'b0;
        end else begin
            op_ack  <= 1'b0;
            op_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cur_code  <= op_code_e'(op_code);
                        cur_tank  <= op_tank;
                        cur_word  <= op_word;
                        cur_whole <= op_whole;
                        op_ack    <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (at_start) begin
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (xfer_last) begin
                        op_done <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == ST_WAIT) || (state == ST_XFER);
    assign mob_valid = (state == ST_XFER) && (cur_code == OP_READ);

    // ------------------------------------------------------------------
    // Tanks
    // ------------------------------------------------------------------
    logic [NUM_TANKS-1:0] tank_out;
    logic [NUM_TANKS-1:0] tank_replace;
    logic [TANK_LEN-1:0]  tank_contents [NUM_TANKS];
    logic                 repl_bit;

    // Clear shares the replace path, feeding zeros instead of mib.
    assign repl_bit = (cur_code == OP_WRITE) ? mib : 1'b0;

    for (genvar g = 0; g < NUM_TANKS; g++) begin : g_tank
        assign tank_replace[g] = (state == ST_XFER) && (cur_code != OP_READ)
                                 && (cur_tank == T_AW'(g));

        delay_tank #(
            .LEN(TANK_LEN)
        ) u_tank (
            .clk      (rack_clk),
            .rst_n    (rack_rst_n),
            .replace  (tank_replace[g]),
            .repl_bit (repl_bit),
            .out_bit  (tank_out[g]),
            .contents (tank_contents[g])
        );
    end

    assign mob = mob_valid & tank_out[cur_tank];

    always_comb begin
        monitor = '0;
        for (int i = 0; i < NUM_TANKS; i++) begin
            if (mon_sel == T_AW'(i)) begin
                monitor = tank_contents[i];
            end
        end
    end

endmodule

// File: tb/tb_memory_rack.sv
// Self-checking bench for memory_rack: directed vector table, multi-cycle corner
// sequences and randomized operations against a word-array model of the store.
module tb_memory_rack;
    import memory_rack_pkg::*;

    localparam int NT = 8;
    localparam int SL = 16;
    localparam int WW = 36;
    localparam int L  = SL * WW;

    localparam int S_NT = 6;
    localparam int S_SL = 4;
    localparam int S_WW = 8;
    localparam int S_L  = S_SL * S_WW;

    logic rack_clk   = 1'b0;
    logic rack_rst_n = 1'b0;

    logic                op_req, op_whole, mib;
    logic [1:0]          op_code;
    logic [TANK_AW-1:0]  op_tank, mon_sel;
    logic [WORD_AW-1:0]  op_word;
    logic                op_ack, op_done, busy, mob, mob_valid;
    logic [DIGIT_AW-1:0] digit_pos;
    logic [WORD_AW-1:0]  word_pos;
    logic [L-1:0]        monitor;

    logic                s_op_req, s_op_whole, s_mib;
    logic [1:0]          s_op_code;
    logic [2:0]          s_op_tank, s_mon_sel;
    logic [1:0]          s_op_word, s_word_pos;
    logic                s_op_ack, s_op_done, s_busy, s_mob, s_mob_valid;
    logic [2:0]          s_digit_pos;
    logic [S_L-1:0]      s_monitor;

    always #5 rack_clk = ~rack_clk;

    memory_rack #(.NUM_TANKS(NT), .STORE_LEN(SL), .WORD_WIDTH(WW)) u_dut (
        .rack_clk(rack_clk), .rack_rst_n(rack_rst_n),
        .op_req(op_req), .op_code(op_code), .op_tank(op_tank), .op_word(op_word),
        .op_whole(op_whole), .mib(mib), .op_ack(op_ack), .op_done(op_done),
        .busy(busy), .mob(mob), .mob_valid(mob_valid), .digit_pos(digit_pos),
        .word_pos(word_pos), .mon_sel(mon_sel), .monitor(monitor)
    );

    memory_rack #(.NUM_TANKS(S_NT), .STORE_LEN(S_SL), .WORD_WIDTH(S_WW)) u_small (
        .rack_clk(rack_clk), .rack_rst_n(rack_rst_n),
        .op_req(s_op_req), .op_code(s_op_code), .op_tank(s_op_tank), .op_word(s_op_word),
        .op_whole(s_op_whole), .mib(s_mib), .op_ack(s_op_ack), .op_done(s_op_done),
        .busy(s_busy), .mob(s_mob), .mob_valid(s_mob_valid), .digit_pos(s_digit_pos),
        .word_pos(s_word_pos), .mon_sel(s_mon_sel), .monitor(s_monitor)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pos      = 0;            // model of the timing chain: word*WW + digit
    logic [L-1:0] model [NT];    // tank contents as seen at counters (0,0)

    typedef struct {
        logic [1:0]    code;
        int            tank;
        int            word;
        logic [WW-1:0] wdata;
        bit            exp_ack;
        logic [WW-1:0] exp_rd;
    } vec_t;

    vec_t         vecs [11];
    logic [L-1:0] rd, wd, tmp, iso_exp;
    int           lat, cnt;
    bit           seen;

    task automatic check(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rack_clk);
        #1;
        pos = (pos + 1) % L;
    endtask

    function automatic logic [L-1:0] rotated(input int t, input int p);
        logic [L-1:0] r;
        for (int j = 0; j < L; j++) r[j] = model[t][(j + p) % L];
        return r;
    endfunction

    task automatic check_monitor(input int sel);
        mon_sel = TANK_AW'(sel);
        #1;
        check($sformatf("monitor tank %0d", sel), monitor, rotated(sel, pos));
        check("counters", {word_pos, digit_pos}, {WORD_AW'(pos / WW), DIGIT_AW'(pos % WW)});
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i <= L && pos != p; i++) tick();
    endtask

    function automatic logic [L-1:0] rand_tank();
        logic [L-1:0] w;
        for (int j = 0; j < L; j += 32) w[j +: 32] = $urandom;
        return w;
    endfunction

    // Issue one accepted operation and follow it to the IDLE cycle after DONE.
    task automatic run_op(input logic [1:0] code, input int tank, input int word,
                          input bit whole, input logic [L-1:0] wdata, input bit noise,
                          output logic [L-1:0] rdata, output int lat_o);
        int n, s, k, bad, ack_bad, b;
        logic [L-1:0] exp_rd;
        n = whole ? L : WW;
        s = whole ? 0 : word * WW;
        op_req = 1'b1; op_code = code; op_tank = TANK_AW'(tank);
        op_word = WORD_AW'(word); op_whole = whole;
        tick();
        check("op_ack on acceptance", op_ack, 1);
        k = ((s - pos) % L + L) % L;
        if (k == 0) k = L;
        bad = 0; ack_bad = 0; lat_o = -1; rdata = '0;
        for (int c = 0; c < k + n; c++) begin
            op_req   = noise;
            op_code  = 2'($urandom_range(0, 2));
            op_tank  = TANK_AW'($urandom_range(0, NT - 1));
            op_word  = WORD_AW'($urandom);
            op_whole = 1'($urandom);
            mib      = 1'($urandom);
            if (c >= k) begin
                b = c - k;
                if (code == OP_WRITE) mib = wdata[b];
                if (mob_valid !== (code == OP_READ)) bad++;
                if (mob_valid === 1'b1) rdata[b] = mob;
            end else if (mob_valid !== 1'b0) begin
                bad++;
            end
            if (mob_valid === 1'b1 && lat_o < 0) lat_o = c;
            if (busy !== 1'b1 || op_done !== 1'b0) bad++;
            if (c > 0 && op_ack !== 1'b0) ack_bad++;
            tick();
        end
        check("DONE cycle op_done/busy/mob_valid", {op_done, busy, mob_valid}, 3'b100);
        if (op_ack !== 1'b0) ack_bad++;
        tick();
        op_req = 1'b0;
        check("IDLE after DONE op_done/op_ack/busy", {op_done, op_ack, busy}, 3'b000);
        check("window timing", bad, 0);
        check("no ack while busy", ack_bad, 0);
        for (int j = 0; j < n; j++) begin
            if (code == OP_WRITE) model[tank][s + j] = wdata[j];
            if (code == OP_CLEAR) model[tank][s + j] = 1'b0;
        end
        if (code == OP_READ) begin
            exp_rd = '0;
            for (int j = 0; j < n; j++) exp_rd[j] = model[tank][s + j];
            check("read data vs model", rdata, exp_rd);
            check("read latency", lat_o, k);
        end
    endtask

    initial begin
        op_req = 0; op_code = 0; op_tank = 0; op_word = 0; op_whole = 0; mib = 0; mon_sel = 0;
        s_op_req = 0; s_op_code = 0; s_op_tank = 0; s_op_word = 0; s_op_whole = 0;
        s_mib = 0; s_mon_sel = 0;
        for (int t = 0; t < NT; t++) model[t] = '0;

        vecs[0]  = '{OP_WRITE, 3, 5,  36'h800000001, 1'b1, 36'h0};
        vecs[1]  = '{OP_READ,  3, 5,  36'h0,         1'b1, 36'h800000001};
        vecs[2]  = '{OP_RSVD,  2, 0,  36'h0,         1'b0, 36'h0};
        vecs[3]  = '{OP_WRITE, 7, 0,  36'hA5A5A5A5A, 1'b1, 36'h0};
        vecs[4]  = '{OP_READ,  7, 0,  36'h0,         1'b1, 36'hA5A5A5A5A};
        vecs[5]  = '{OP_READ,  7, 1,  36'h0,         1'b1, 36'h0};
        vecs[6]  = '{OP_WRITE, 6, 15, 36'hFFFFFFFFF, 1'b1, 36'h0};
        vecs[7]  = '{OP_CLEAR, 6, 15, 36'h0,         1'b1, 36'h0};
        vecs[8]  = '{OP_READ,  6, 15, 36'h0,         1'b1, 36'h0};
        vecs[9]  = '{OP_READ,  3, 4,  36'h0,         1'b1, 36'h0};
        vecs[10] = '{OP_RSVD,  3, 5,  36'h0,         1'b0, 36'h0};

        // Reset state
        #2;
        check("outputs in reset", {op_ack, op_done, busy, mob, mob_valid}, 0);
        check("monitor in reset", monitor, 0);
        tick(); tick();
        rack_rst_n = 1'b1;
        pos = 0;
        check("counters after reset", {word_pos, digit_pos}, 0);
        for (int t = 0; t < NT; t++) begin
            mon_sel = TANK_AW'(t);
            #1;
            check($sformatf("monitor zero tank %0d", t), monitor, 0);
        end
        tick();
        check("first edge counters", {word_pos, digit_pos}, {4'd0, 6'd1});

        // Out-of-range tank on a rack whose tank field can express it
        s_op_req = 1'b1; s_op_tank = 3'd6;
        tick();
        check("tank 6 of 6 ignored", {s_op_ack, s_busy}, 0);
        s_op_tank = 3'd7;
        tick();
        check("tank 7 of 6 ignored", {s_op_ack, s_busy}, 0);
        s_op_tank = 3'd5; s_op_word = 2'd2;
        tick();
        check("tank 5 of 6 accepted", {s_op_ack, s_busy}, 2'b11);
        s_op_req = 1'b0;
        seen = 0; cnt = 0;
        for (int i = 0; i < S_L + S_WW + 4 && !seen; i++) begin
            tick();
            if (s_mob_valid === 1'b1) cnt++;
            if (s_op_done === 1'b1) seen = 1;
        end
        check("small rack op_done", seen, 1);
        check("small rack read cycles", cnt, S_WW);

        // Isolation: fill tank 0, clear its last word
        run_op(OP_WRITE, 0, 0, 1'b1, '1, 1'b0, rd, lat);
        run_op(OP_CLEAR, 0, 15, 1'b0, '0, 1'b1, rd, lat);
        wait_pos(0);
        iso_exp = {{WW{1'b0}}, {(L - WW){1'b1}}};
        mon_sel = 0;
        #1;
        check("isolation tank 0", monitor, iso_exp);
        for (int t = 1; t < NT; t++) begin
            mon_sel = TANK_AW'(t);
            #1;
            check($sformatf("isolation tank %0d", t), monitor, 0);
        end

        // Directed vector table
        for (int v = 0; v < 11; v++) begin
            if (vecs[v].exp_ack) begin
                run_op(vecs[v].code, vecs[v].tank, vecs[v].word, 1'b0,
                       L'(vecs[v].wdata), v[0], rd, lat);
                if (vecs[v].code == OP_READ)
                    check($sformatf("table read %0d", v), rd[WW-1:0], vecs[v].exp_rd);
            end else begin
                op_req = 1'b1; op_code = vecs[v].code;
                op_tank = TANK_AW'(vecs[v].tank); op_word = WORD_AW'(vecs[v].word);
                op_whole = 1'b0;
                tick();
                check($sformatf("table reject %0d ack/busy", v), {op_ack, busy}, 0);
                tick();
                check($sformatf("table reject %0d busy", v), {op_ack, busy}, 0);
                op_req = 1'b0;
                tick();
            end
        end
        wait_pos(0);
        mon_sel = 3;
        #1;
        tmp = monitor;
        check("monitor tank 3 bits 215:180", tmp[215:180], 36'h800000001);

        // Latency bounds
        wait_pos(L - 1);
        run_op(OP_READ, 3, 0, 1'b0, '0, 1'b0, rd, lat);
        check("latency word 0 from (0,0)", lat, L);
        wait_pos(0);
        run_op(OP_READ, 3, 1, 1'b0, '0, 1'b0, rd, lat);
        check("latency word 1 from (0,1)", lat, 35);

        // Randomized operations against the model
        for (int i = 0; i < 14; i++) begin
            int tank, word;
            bit whole;
            logic [1:0] code;
            repeat ($urandom_range(0, 40)) tick();
            code  = 2'($urandom_range(0, 2));
            tank  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NT - 1) : $urandom_range(0, 1);
            word  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, SL - 1) : $urandom_range(0, 3);
            whole = ($urandom_range(0, 7) == 0);
            wd    = rand_tank();
            run_op(code, tank, word, whole, wd, 1'($urandom), rd, lat);
            check_monitor(tank);
            check_monitor($urandom_range(0, NT - 1));
        end

        // Reset in the middle of a whole-tank write
        op_req = 1'b1; op_code = OP_WRITE; op_tank = 2; op_whole = 1'b1;
        tick();
        check("abort op ack", op_ack, 1);
        op_req = 1'b0; mib = 1'b1;
        repeat (L - pos + 100) tick();
        check("abort mid-xfer busy", busy, 1);
        rack_rst_n = 1'b0;
        #1;
        check("abort outputs", {op_ack, op_done, busy, mob, mob_valid}, 0);
        for (int t = 0; t < NT; t++) begin
            mon_sel = TANK_AW'(t);
            #1;
            check($sformatf("abort monitor tank %0d", t), monitor, 0);
        end
        tick(); tick();
        rack_rst_n = 1'b1;
        pos = 0;
        for (int t = 0; t < NT; t++) model[t] = '0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (op_done !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        check("no op_done/busy after abort", seen, 0);
        check_monitor(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
